// File: rtl/inst_mem_responder.sv
// Instruction-fetch read responder: AR/R handshake in front of a
// word-addressed instruction array with a fixed response latency.
`timescale 1ns/1ps
module inst_mem_responder #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned        LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ADDR_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [ADDR_W-1:0]     ld_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hs;
  logic [ADDR_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   word_off;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                misaligned;
  logic                out_of_range;
  logic [1:0]          resp_sel;
  logic [ADDR_W-1:0]   data_sel;

  // Address decode; below-base is checked explicitly so the subtraction cannot wrap into range
  assign word_off     = (araddr - BASE_ADDR) >> 2;
  assign word_idx     = word_off[DEPTH_LOG2-1:0];
  assign misaligned   = (araddr[1:0] != 2'b00);
  assign out_of_range = (araddr < BASE_ADDR) || ((word_off >> DEPTH_LOG2) != '0);

  // Response selection: misalignment outranks out-of-range
  always_comb begin
    resp_sel = RESP_OKAY;
    data_sel = '0;
    if (misaligned) begin
      resp_sel = RESP_SLVERR;
    end else if (out_of_range) begin
      resp_sel = RESP_DECERR;
    end else begin
      data_sel = mem[word_idx];
    end
  end

  // Load port; array contents survive reset
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Next-state logic for the AR -> WAIT -> R sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hs      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid && arready) begin
          hs = 1'b1;
          if (LATENCY <= 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered outputs; response captured at the handshake edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arready <= (state_d == S_IDLE);
      rvalid  <= (state_d == S_RESP);
      if (hs) begin
        rdata <= data_sel;
        rresp <= resp_sel;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomised bench for inst_mem_responder at LATENCY=1 and LATENCY=4.
`timescale 1ns/1ps
module tb_inst_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  logic [31:0] mem [DEPTH];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_mem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_mem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: what the responder must return for byte address a, from the array model
  function automatic void ref_resp(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    longint unsigned aa;
    longint unsigned word;
    aa = a;
    d  = 32'h0;
    if (a[1:0] != 2'b00) begin
      r = 2'b10;
    end else if (aa < 64'(BASE)) begin
      r = 2'b11;
    end else begin
      word = (aa - 64'(BASE)) / 4;
      if (word >= DEPTH) begin
        r = 2'b11;
      end else begin
        r = 2'b00;
        d = mem[int'(word)];
      end
    end
  endfunction

  // Advance to the next falling edge; a load driven in the previous cycle is now in the array
  task automatic step();
    @(negedge clk);
    if (ld_en) begin
      mem[ld_addr] = ld_data;
      ld_en = 1'b0;
    end
  endtask

  task automatic load(input logic [11:0] idx, input logic [31:0] val);
    ld_en = 1'b1; ld_addr = idx; ld_data = val;
    step();
  endtask

  // One fetch. mode 0: no load, 1: load on the handshake edge, 2: load on the edge after
  task automatic fetch(input int d, input logic [31:0] a, input int stall,
                       input int mode, input logic [11:0] la, input logic [31:0] lv);
    logic [31:0] ed;
    logic [1:0]  er;
    int k;
    araddr[d]  = a;
    arvalid[d] = 1'b1;
    rready[d]  = (stall == 0);
    k = 0;
    while (arready[d] !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("ar_ready", 32'(arready[d]), 32'd1);
    ref_resp(a, ed, er);
    if (mode == 1) begin
      ld_en = 1'b1; ld_addr = la; ld_data = lv;
    end
    step();
    arvalid[d] = 1'b0;
    if (mode == 2) begin
      ld_en = 1'b1; ld_addr = la; ld_data = lv;
    end
    k = 0;
    while (rvalid[d] !== 1'b1 && k < 20) begin
      chk("busy_ar", 32'(arready[d]), 32'd0);
      step();
      k++;
    end
    chk("latency", 32'(k), 32'(lat_of(d) - 1));
    chk("rresp", 32'(rresp[d]), 32'(er));
    chk("rdata", rdata[d], ed);
    chk("resp_ar", 32'(arready[d]), 32'd0);
    for (int i = 1; i <= stall; i++) begin
      step();
      chk("hold_rvalid", 32'(rvalid[d]), 32'd1);
      chk("hold_rdata", rdata[d], ed);
      chk("hold_rresp", 32'(rresp[d]), 32'(er));
      chk("hold_ar", 32'(arready[d]), 32'd0);
    end
    rready[d] = 1'b1;
    step();
    chk("done_rvalid", 32'(rvalid[d]), 32'd0);
    chk("done_ar", 32'(arready[d]), 32'd1);
    rready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [11:0] w;
    int cls;
    rst   = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ar", 32'(arready[d]), 32'd0);
      chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
      chk("rst_rresp", 32'(rresp[d]), 32'd0);
    end

    // Preload the whole array through the load port (also legal while in reset)
    for (int i = 0; i < DEPTH; i++) load(12'(i), $urandom);
    load(12'd0, 32'h0000_0413);
    load(12'd1, 32'h0010_0093);
    rst = 1'b1;
    step();
    chk("rel_ar0", 32'(arready[0]), 32'd1);
    chk("rel_ar1", 32'(arready[1]), 32'd1);

    // Back-to-back fetches at LATENCY=1, with absolute expected words
    fetch(0, 32'h8000_0000, 0, 0, 12'd0, 32'd0);
    chk("word0", rdata[0], 32'h0000_0413);
    fetch(0, 32'h8000_0004, 0, 0, 12'd0, 32'd0);
    chk("word1", rdata[0], 32'h0010_0093);

    // LATENCY=4, then a 5-cycle stall
    fetch(1, 32'h8000_0004, 0, 0, 12'd0, 32'd0);
    fetch(1, 32'h8000_0000, 5, 0, 12'd0, 32'd0);

    // Error responses on both latencies
    for (int d = 0; d < 2; d++) begin
      fetch(d, 32'h8000_0002, 0, 0, 12'd0, 32'd0);
      chk("slverr", 32'(rresp[d]), 32'd2);
      fetch(d, 32'h7FFF_FFFC, 1, 0, 12'd0, 32'd0);
      chk("decerr_lo", 32'(rresp[d]), 32'd3);
      fetch(d, 32'h8000_4000, 0, 0, 12'd0, 32'd0);
      chk("decerr_hi", 32'(rresp[d]), 32'd3);
      fetch(d, 32'hFFFF_FFFC, 0, 0, 12'd0, 32'd0);
      fetch(d, 32'h8000_3FFC, 0, 0, 12'd0, 32'd0);
    end

    // Same-edge load returns the old word; the next fetch sees the new one
    load(12'd3, 32'h1234_5678);
    fetch(0, 32'h8000_000C, 0, 1, 12'd3, 32'hDEAD_BEEF);
    chk("rbw_old", rdata[0], 32'h1234_5678);
    fetch(0, 32'h8000_000C, 0, 0, 12'd0, 32'd0);
    chk("rbw_new", rdata[0], 32'hDEAD_BEEF);

    // Reset during WAIT abandons the fetch
    araddr[1] = 32'h8000_0000; arvalid[1] = 1'b1; rready[1] = 1'b1;
    chk("pre_rst_ar", 32'(arready[1]), 32'd1);
    step();
    arvalid[1] = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ar", 32'(arready[1]), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid[1]), 32'd0);
    repeat (3) begin
      step();
      chk("in_rst_ar", 32'(arready[1]), 32'd0);
      chk("in_rst_rvalid", 32'(rvalid[1]), 32'd0);
    end
    rst = 1'b1;
    repeat (6) begin
      step();
      chk("post_rst_rvalid", 32'(rvalid[1]), 32'd0);
      chk("post_rst_ar", 32'(arready[1]), 32'd1);
    end
    rready[1] = 1'b0;
    fetch(1, 32'h8000_0004, 0, 0, 12'd0, 32'd0);
    chk("post_rst_word1", rdata[1], 32'h0010_0093);

    // Randomised traffic
    for (int n = 0; n < 160; n++) begin
      cls = $urandom_range(0, 5);
      w   = 12'($urandom);
      case (cls)
        0, 1: a = BASE + {18'd0, w, 2'b00};
        2:    a = BASE + {18'd0, w, 2'b00} + 32'($urandom_range(1, 3));
        3:    a = $urandom_range(0, 32'h7FFF_FFFF) & 32'hFFFF_FFFC;
        4:    a = (BASE + 32'h0000_4000 + $urandom_range(0, 32'h7FFF_BFFF)) & 32'hFFFF_FFFC;
        default: a = BASE + ($urandom_range(0, 1) ? 32'h0000_3FFC : 32'h0000_4000);
      endcase
      fetch($urandom_range(0, 1), a, $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 1) ? a[13:2] : 12'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Slave end of the instruction-fetch read channel: accepts a fetch address from the core, returns the 32-bit instruction word after a fixed, parameterised latency.
- Uses an AXI-lite-style read handshake (AR/R channels) so the core can move from a combinational `inst` input to a stalling fetch unit.
- Holds an internal word-addressed instruction array, preloaded through a separate load port by the testbench or boot logic.

Parameters:
- ADDR_W, 32, address and data width; fixed at 32 for RV32.
- DEPTH_LOG2, 12, log2 of the array depth in 32-bit words (default 4096 words = 16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 1, cycles from the AR handshake to rvalid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr  in  32  fetch byte address (the PC).
- arvalid  in  1  address valid.
- arready  out  1  responder can accept an address.
- rdata  out  32  instruction word.
- rresp  out  2  00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range).
- rvalid  out  1  response valid.
- rready  in  1  core accepts the response.
- ld_en  in  1  synchronous array write enable.
- ld_addr  in  DEPTH_LOG2  word index to write.
- ld_data  in  32  word to write.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; latency counter is cleared.
  - rvalid=0, rdata=0, rresp=00.
  - arready is forced to 0 while rst=0.
  - The array is not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - arready=1, rvalid=0.
  - On arvalid&&arready (the handshake cycle), capture the response and move to WAIT, or directly to RESP when LATENCY=1. The captured response is:
    - araddr[1:0]!=0: rresp=10, rdata=0.
    - Else if (araddr-BASE_ADDR)>>2 >= 2^DEPTH_LOG2, or araddr<BASE_ADDR: rresp=11, rdata=0.
    - Else rresp=00, rdata=array[(araddr-BASE_ADDR)>>2].
  - A misaligned address takes priority over an out-of-range address.
- WAIT:
  - arready=0.
  - The counter is loaded with LATENCY-2 at the handshake and decremented each cycle.
  - Move to RESP when it reads 0.
  - rvalid therefore rises exactly LATENCY cycles after the handshake edge.
- RESP:
  - rvalid=1, arready=0.
  - rdata and rresp stay stable until rvalid&&rready.
  - On that edge, go to IDLE. rvalid drops and arready rises in the following cycle; no same-cycle response and new address.
  - rready held high before rvalid is legal and has no effect.
  - arvalid asserted outside IDLE is ignored; the core must hold it until arready.
- Load port:
  - ld_en writes ld_data to array[ld_addr] on the rising edge, in any state.
  - The array is read at the handshake edge. A write to the same word in the same cycle returns the old data (read-before-write).
  - Writes after the handshake do not affect the in-flight response.
- Address arithmetic is unsigned 32-bit; the subtraction must not wrap into range. Treat araddr<BASE_ADDR as DECERR explicitly.
- Reset asserted mid-transaction: the transaction is abandoned with no response; after release the block is in IDLE with arready=1.
- Throughput: one response per LATENCY+1 cycles at best (with rready held high).

Test Plan:
- Preload word 0 = 32'h0000_0413, word 1 = 32'h0010_0093. LATENCY=1, rready=1, araddr=32'h8000_0000 then 32'h8000_0004 → rvalid one cycle after each handshake, rdata 32'h0000_0413 then 32'h0010_0093, rresp=00, arready low while busy.
- LATENCY=4, fetch 32'h8000_0004 → rvalid exactly 4 cycles after the handshake edge, arready=0 throughout.
- rready held low for 5 cycles in RESP → rvalid, rdata and rresp stable all 5 cycles. Accept on the 6th → IDLE, arready=1 the next cycle.
- araddr=32'h8000_0002 → rresp=10, rdata=0. araddr=32'h7FFF_FFFC and 32'h8000_4000 (DEPTH_LOG2=12) → rresp=11, rdata=0.
- ld_en writing word 3 = 32'hDEAD_BEEF in the same cycle as the handshake for 32'h8000_000C → old word returned. A subsequent fetch returns 32'hDEAD_BEEF.
- rst pulled low during WAIT → rvalid never rises, arready=0 while in reset. After release, arready=1 and the next fetch completes normally.
